// File: rtl/rcc_pkg.sv
// Shared definitions for the RCC reset sequencer: state encodings, reset-cause
// bit positions and default timing parameters.
package rcc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t WAIT_LOCK = 3'd0;
  localparam state_t HOLD      = 3'd1;
  localparam state_t REL_SYS   = 3'd2;
  localparam state_t REL_APB0  = 3'd3;
  localparam state_t REL_APB1  = 3'd4;
  localparam state_t REL_APB2  = 3'd5;
  localparam state_t RUN       = 3'd6;

  localparam int POR = 0;
  localparam int SW  = 1;
  localparam int WDG = 2;

  localparam logic [2:0] CAUSE_AT_RESET = 3'b001;

  localparam int DEF_LOCK_FILTER    = 8;
  localparam int DEF_STRETCH_CYCLES = 16;
  localparam int DEF_STAGE_GAP      = 4;
  localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/rcc_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by a
// synchronous active-high reset.
module rcc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep both flops sampling on the same edge,
  // which is what makes this a two-stage shift rather than a single wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rcc_rst_seq.sv
// RCC reset sequencer: qualifies PLL lock, stretches reset, releases the system
// and APB domains in a staggered order, and records the last reset cause.
module rcc_rst_seq
  import rcc_pkg::*;
#(
  parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       module_clk,
  input  logic       module_rst,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  input  logic       wdg_rst_req,
  input  logic       cause_clr,
  output logic       sys_root_rstn,
  output logic       apb0_root_rstn,
  output logic       apb1_root_rstn,
  output logic       apb2_root_rstn,
  output logic       rst_busy,
  output logic [2:0] rst_cause
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       rel, rel_nxt;   // {apb2, apb1, apb0, sys}, 1 = released
  logic [2:0]       cause_nxt;
  logic             lock_s;
  logic             req;

  rcc_sync2 u_lock_sync (
    .clk (module_clk),
    .rst (module_rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign req = sw_rst_req | wdg_rst_req;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    rel_nxt   = rel;

    unique case (state)
      WAIT_LOCK: begin
        rel_nxt = '0;
        if (!lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(LOCK_FILTER)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        rel_nxt = '0;
        if (cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
          state_nxt  = REL_SYS;
          cnt_nxt    = '0;
          rel_nxt[0] = 1'b1;
        end
      end
      REL_SYS: begin
        if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          state_nxt  = REL_APB0;
          cnt_nxt    = '0;
          rel_nxt[1] = 1'b1;
        end
      end
      REL_APB0: begin
        if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          state_nxt  = REL_APB1;
          cnt_nxt    = '0;
          rel_nxt[2] = 1'b1;
        end
      end
      REL_APB1: begin
        if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          state_nxt  = REL_APB2;
          cnt_nxt    = '0;
          rel_nxt[3] = 1'b1;
        end
      end
      REL_APB2: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
      RUN: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
        rel_nxt   = '0;
      end
    endcase

    // Lock loss outranks a request; both abort whatever progression was chosen.
    if (state != WAIT_LOCK) begin
      if (!lock_s) begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
        rel_nxt   = '0;
      end else if (req) begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
        rel_nxt   = '0;
      end
    end

    cause_nxt      = rst_cause & {3{~cause_clr}};
    cause_nxt[SW]  = cause_nxt[SW]  | sw_rst_req;
    cause_nxt[WDG] = cause_nxt[WDG] | wdg_rst_req;
  end

  // Busy drops together with the last domain release, one edge ahead of RUN.
  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rel       <= '0;
      rst_busy  <= 1'b1;
      rst_cause <= CAUSE_AT_RESET;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rel       <= rel_nxt;
      rst_busy  <= ~rel_nxt[3];
      rst_cause <= cause_nxt;
    end
  end

  assign sys_root_rstn  = rel[0];
  assign apb0_root_rstn = rel[1];
  assign apb1_root_rstn = rel[2];
  assign apb2_root_rstn = rel[3];

endmodule
